// File: rtl/hc_sr04_pkg.sv
// Shared types and timing defaults for the HC-SR04 multi-channel scanner.
// Default constants assume a 50 MHz system clock.
package hc_sr04_pkg;

    typedef enum logic [2:0] {
        IDLE,
        TRIG,
        WAIT_RISE,
        MEAS,
        GUARD
    } state_e;

    localparam int DEF_NUM_CH      = 4;
    localparam int DEF_MAX_RANGE   = 400;
    localparam int DEF_CCL_SZ      = 2941;
    localparam int DEF_TRIG_CYC    = 500;
    localparam int DEF_RISE_TO_CYC = 1_500_000;
    localparam int DEF_GUARD_CYC   = 3_000_000;

    // Bits needed to index n distinct values, never less than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/hc_sr04_scanner_echo_meter.sv
// Echo pulse meter: edge detection on the selected, already-synchronised echo,
// a CCL_SZ-clock prescaler and a saturating centimetre counter.
module echo_meter
    import hc_sr04_pkg::*;
#(
    parameter int CCL_SZ    = DEF_CCL_SZ,
    parameter int MAX_RANGE = DEF_MAX_RANGE,
    parameter int DST_SZ    = idx_width(MAX_RANGE + 1)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              echo_i,
    input  logic              start_i,
    input  logic              en_i,
    output logic [DST_SZ-1:0] cm_o,
    output logic              sat_o,
    output logic              rise_o,
    output logic              fall_o
);

    localparam int PSC_SZ = idx_width(CCL_SZ);

    logic              echo_q;
    logic [PSC_SZ-1:0] psc_q, psc_d;
    logic [DST_SZ-1:0] cm_q, cm_d;

    // The counter freezes once saturated so the owner can read MAX_RANGE back.
    always_comb begin
        psc_d = psc_q;
        cm_d  = cm_q;
        if (start_i) begin
            psc_d = '0;
            cm_d  = '0;
        end else if (en_i && !sat_o) begin
            if (psc_q == PSC_SZ'(CCL_SZ - 1)) begin
                psc_d = '0;
                cm_d  = cm_q + DST_SZ'(1);
            end else begin
                psc_d = psc_q + PSC_SZ'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            echo_q <= 1'b0;
            psc_q  <= '0;
            cm_q   <= '0;
        end else begin
            echo_q <= echo_i;
            psc_q  <= psc_d;
            cm_q   <= cm_d;
        end
    end

    assign cm_o   = cm_q;
    assign sat_o  = (cm_q == DST_SZ'(MAX_RANGE));
    assign rise_o = echo_i & ~echo_q;
    assign fall_o = ~echo_i & echo_q;

endmodule

// File: rtl/hc_sr04_scanner.sv
// Round-robin HC-SR04 scanner: triggers each sensor in turn and publishes a distance bank.
// Define HC_SR04_AVG_EN to average each in-range result with the previous in-range one.
module hc_sr04_scanner
    import hc_sr04_pkg::*;
#(
    parameter int NUM_CH      = DEF_NUM_CH,
    parameter int MAX_RANGE   = DEF_MAX_RANGE,
    parameter int CCL_SZ      = DEF_CCL_SZ,
    parameter int TRIG_CYC    = DEF_TRIG_CYC,
    parameter int RISE_TO_CYC = DEF_RISE_TO_CYC,
    parameter int GUARD_CYC   = DEF_GUARD_CYC,
    localparam int DST_SZ     = idx_width(MAX_RANGE + 1),
    localparam int CH_SZ      = idx_width(NUM_CH)
) (
    input  logic                     CLK,
    input  logic                     RST_n,
    input  logic                     I_EN,
    input  logic [NUM_CH-1:0]        I_ECHO,
    output logic [NUM_CH-1:0]        O_TRIG,
    output logic [NUM_CH*DST_SZ-1:0] O_DST,
    output logic [NUM_CH-1:0]        O_OOR,
    output logic                     O_VLD,
    output logic [CH_SZ-1:0]         O_CH,
    output logic                     O_FL
);

    localparam int CNT_MAX_A = (TRIG_CYC > RISE_TO_CYC) ? TRIG_CYC : RISE_TO_CYC;
    localparam int CNT_MAX   = (CNT_MAX_A > GUARD_CYC) ? CNT_MAX_A : GUARD_CYC;
    localparam int CNT_W     = idx_width(CNT_MAX);

    logic [NUM_CH-1:0]        sync1_q, sync2_q;
    state_e                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [CH_SZ-1:0]         ch_q, ch_d;
    logic [NUM_CH*DST_SZ-1:0] dst_q, dst_d;
    logic [NUM_CH-1:0]        oor_q, oor_d;
    logic                     vld_q, vld_d;

    logic              echo_sel;
    logic              meter_start, meter_en;
    logic              echo_rise, echo_fall, cm_sat;
    logic [DST_SZ-1:0] cm_val;
    logic              wr, wr_oor;
    logic [DST_SZ-1:0] wr_raw, wr_val, old_val;

    // Two-flop synchronisers on every echo line; only the selected one is consumed.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= I_ECHO;
            sync2_q <= sync2_q == sync2_q ? sync1_q : sync1_q;
        end
    end

    assign echo_sel = sync2_q[ch_q];
    assign meter_en = (state_q == MEAS);

    echo_meter #(
        .CCL_SZ    (CCL_SZ),
        .MAX_RANGE (MAX_RANGE),
        .DST_SZ    (DST_SZ)
    ) u_meter (
        .clk_i   (CLK),
        .rst_ni  (RST_n),
        .echo_i  (echo_sel),
        .start_i (meter_start),
        .en_i    (meter_en),
        .cm_o    (cm_val),
        .sat_o   (cm_sat),
        .rise_o  (echo_rise),
        .fall_o  (echo_fall)
    );

    // Saturation is tested before the falling edge so a tie reports out-of-range.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ch_d        = ch_q;
        meter_start = 1'b0;
        wr          = 1'b0;
        wr_oor      = 1'b0;
        wr_raw      = '0;
        unique case (state_q)
            IDLE: begin
                if (I_EN) begin
                    state_d = TRIG;
                    cnt_d   = '0;
                end
            end
            TRIG: begin
                if (cnt_q == CNT_W'(TRIG_CYC - 1)) begin
                    state_d = WAIT_RISE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WAIT_RISE: begin
                if (echo_rise) begin
                    state_d     = MEAS;
                    meter_start = 1'b1;
                end else if (cnt_q == CNT_W'(RISE_TO_CYC - 1)) begin
                    state_d = GUARD;
                    cnt_d   = '0;
                    wr      = 1'b1;
                    wr_oor  = 1'b1;
                    wr_raw  = DST_SZ'(MAX_RANGE);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            MEAS: begin
                if (cm_sat) begin
                    state_d = GUARD;
                    cnt_d   = '0;
                    wr      = 1'b1;
                    wr_oor  = 1'b1;
                    wr_raw  = DST_SZ'(MAX_RANGE);
                end else if (echo_fall) begin
                    state_d = GUARD;
                    cnt_d   = '0;
                    wr      = 1'b1;
                    wr_raw  = cm_val;
                end
            end
            GUARD: begin
                if (cnt_q != CNT_W'(GUARD_CYC - 1)) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else if (!echo_sel) begin
                    cnt_d   = '0;
                    ch_d    = (ch_q == CH_SZ'(NUM_CH - 1)) ? '0 : ch_q + CH_SZ'(1);
                    state_d = I_EN ? TRIG : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign old_val = dst_q[int'(ch_q)*DST_SZ +: DST_SZ];

`ifdef HC_SR04_AVG_EN
    logic [NUM_CH-1:0] hist_q, hist_d;
    logic [DST_SZ:0]   avg_sum;

    // hist marks channels whose stored value is an in-range result worth averaging with.
    always_comb begin
        avg_sum = {1'b0, old_val} + {1'b0, wr_raw} + (DST_SZ + 1)'(1);
        wr_val  = wr_raw;
        hist_d  = hist_q;
        if (wr) begin
            if (!wr_oor && hist_q[ch_q]) begin
                wr_val = avg_sum[DST_SZ:1];
            end
            hist_d[ch_q] = !wr_oor;
        end
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            hist_q <= '0;
        end else begin
            hist_q <= hist_d;
        end
    end
`else
    always_comb begin
        wr_val = wr_raw;
    end
`endif

    always_comb begin
        dst_d = dst_q;
        oor_d = oor_q;
        vld_d = wr;
        if (wr) begin
            dst_d[int'(ch_q)*DST_SZ +: DST_SZ] = wr_val;
            oor_d[ch_q]                        = wr_oor;
        end
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ch_q    <= '0;
            dst_q   <= '0;
            oor_q   <= '0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ch_q    <= ch_d;
            dst_q   <= dst_d;
            oor_q   <= oor_d;
            vld_q   <= vld_d;
        end
    end

    always_comb begin
        O_TRIG = '0;
        if (state_q == TRIG) begin
            O_TRIG[ch_q] = 1'b1;
        end
    end

    assign O_DST = dst_q;
    assign O_OOR = oor_q;
    assign O_VLD = vld_q;
    assign O_CH  = ch_q;
    assign O_FL  = (state_q != IDLE);

endmodule

// File: tb/tb_hc_sr04_scanner.sv
// Directed bench for hc_sr04_scanner with shortened timing; covers nominal, timeout,
// saturation, channel wrap, enable drop, async reset and the HC_SR04_AVG_EN write path.
module tb_hc_sr04_scanner;

    localparam int NUM_CH      = 4;
    localparam int MAX_RANGE   = 20;
    localparam int CCL_SZ      = 10;
    localparam int TRIG_CYC    = 5;
    localparam int RISE_TO_CYC = 200;
    localparam int GUARD_CYC   = 50;
    localparam int DST_SZ      = 5;
    localparam int CH_SZ       = 2;

    logic                     CLK = 1'b0;
    logic                     RST_n = 1'b0;
    logic                     I_EN = 1'b0;
    logic [NUM_CH-1:0]        I_ECHO = '0;
    logic [NUM_CH-1:0]        O_TRIG;
    logic [NUM_CH*DST_SZ-1:0] O_DST;
    logic [NUM_CH-1:0]        O_OOR;
    logic                     O_VLD;
    logic [CH_SZ-1:0]         O_CH;
    logic                     O_FL;

    int errors = 0;
    int checks = 0;

    always #5 CLK = ~CLK;

    hc_sr04_scanner #(
        .NUM_CH      (NUM_CH),
        .MAX_RANGE   (MAX_RANGE),
        .CCL_SZ      (CCL_SZ),
        .TRIG_CYC    (TRIG_CYC),
        .RISE_TO_CYC (RISE_TO_CYC),
        .GUARD_CYC   (GUARD_CYC)
    ) dut (
        .CLK    (CLK),
        .RST_n  (RST_n),
        .I_EN   (I_EN),
        .I_ECHO (I_ECHO),
        .O_TRIG (O_TRIG),
        .O_DST  (O_DST),
        .O_OOR  (O_OOR),
        .O_VLD  (O_VLD),
        .O_CH   (O_CH),
        .O_FL   (O_FL)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic checkRange(input string tag, input int observed, input int lo, input int hi);
        checks++;
        assert (observed >= lo && observed <= hi) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d..%0d", tag, observed, lo, hi);
        end
    endtask

    task automatic waitTrig(input int ch, input int budget, output int cycles);
        logic [NUM_CH-1:0] tgt;
        tgt    = 4'b0001 << ch;
        cycles = 0;
        while (O_TRIG !== tgt && cycles < budget) begin
            @(negedge CLK);
            cycles++;
        end
        checkOutput($sformatf("trig_ch%0d", ch), 32'(O_TRIG), 32'(tgt));
    endtask

    task automatic waitTrigLow(input int budget, output int cycles);
        cycles = 0;
        while (O_TRIG !== '0 && cycles < budget) begin
            @(negedge CLK);
            cycles++;
        end
        checkOutput("trig_low", 32'(O_TRIG), 0);
    endtask

    task automatic waitVld(input int budget, output int cycles);
        cycles = 0;
        while (O_VLD !== 1'b1 && cycles < budget) begin
            @(negedge CLK);
            cycles++;
        end
        checkOutput("vld_seen", 32'(O_VLD), 1);
    endtask

    task automatic applyStimulus(input int ch, input int len);
        if (len > 0) begin
            I_ECHO[ch] = 1'b1;
            repeat (len) @(negedge CLK);
            I_ECHO[ch] = 1'b0;
        end
    endtask

    task automatic runChannel(input int ch, input int len);
        int c;
        waitTrig(ch, 400, c);
        waitTrigLow(20, c);
        applyStimulus(ch, len);
        waitVld(400, c);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int c;
        int gap;

        repeat (3) @(negedge CLK);
        checkOutput("rst_trig", 32'(O_TRIG), 0);
        checkOutput("rst_dst", 32'(O_DST), 0);
        checkOutput("rst_oor", 32'(O_OOR), 0);
        checkOutput("rst_vld", 32'(O_VLD), 0);
        checkOutput("rst_ch", 32'(O_CH), 0);
        checkOutput("rst_fl", 32'(O_FL), 0);

        RST_n = 1'b1;
        repeat (3) @(negedge CLK);
        checkOutput("idle_no_en_fl", 32'(O_FL), 0);

        // Nominal ch0: 125-clock echo truncates to 12 cm.
        I_EN = 1'b1;
        waitTrig(0, 20, c);
        checkOutput("busy_fl", 32'(O_FL), 1);
        gap = 0;
        while (O_TRIG[0] === 1'b1 && gap < 20) begin
            gap++;
            @(negedge CLK);
        end
        checkOutput("trig0_width", 32'(gap), TRIG_CYC);
        applyStimulus(0, 125);
        waitVld(20, c);
        checkOutput("nom_ch", 32'(O_CH), 0);
        checkOutput("nom_dst0", 32'(O_DST[4:0]), 12);
        checkOutput("nom_oor0", 32'(O_OOR[0]), 0);
        @(negedge CLK);
        gap = 1;
        checkOutput("vld_one_cycle", 32'(O_VLD), 0);
        waitTrig(1, 100, c);
        gap += c;
        checkRange("guard_gap", gap, GUARD_CYC, GUARD_CYC + 2);

        // ch1 never answers: result lands RISE_TO_CYC clocks after the trigger falls.
        waitTrigLow(20, c);
        waitVld(300, c);
        checkOutput("rise_to_latency", 32'(c), RISE_TO_CYC);
        checkOutput("to_ch", 32'(O_CH), 1);
        checkOutput("to_dst1", 32'(O_DST[9:5]), MAX_RANGE);
        checkOutput("to_oor1", 32'(O_OOR[1]), 1);
        checkOutput("to_dst0_hold", 32'(O_DST[4:0]), 12);

        // ch2 echo stuck high for 500 clocks: saturates, and ch3 waits for the echo to drop.
        waitTrig(2, 100, c);
        waitTrigLow(20, c);
        I_ECHO[2] = 1'b1;
        waitVld(300, c);
        checkOutput("sat_ch", 32'(O_CH), 2);
        checkOutput("sat_dst2", 32'(O_DST[14:10]), MAX_RANGE);
        checkOutput("sat_oor2", 32'(O_OOR[2]), 1);
        gap = 0;
        repeat (500 - c) begin
            @(negedge CLK);
            if (O_TRIG !== '0) gap++;
        end
        checkOutput("no_trig_echo_high", 32'(gap), 0);
        I_ECHO[2] = 1'b0;
        waitTrig(3, 20, c);
        checkRange("ch3_after_drop", c, 1, 6);

        runChannel(3, 0);
        checkOutput("to_ch3", 32'(O_CH), 3);
        checkOutput("to_oor3", 32'(O_OOR[3]), 1);

        // Wrap to ch0, then drop enable mid-measurement.
        waitTrig(0, 100, c);
        checkOutput("wrap_ch", 32'(O_CH), 0);
        waitTrigLow(20, c);
        I_ECHO[0] = 1'b1;
        repeat (30) @(negedge CLK);
        I_EN = 1'b0;
        repeat (95) @(negedge CLK);
        I_ECHO[0] = 1'b0;
        waitVld(20, c);
        checkOutput("endrop_dst0", 32'(O_DST[4:0]), 12);
        checkOutput("endrop_oor0", 32'(O_OOR[0]), 0);
        c = 0;
        while (O_FL !== 1'b0 && c < 100) begin
            @(negedge CLK);
            c++;
        end
        checkOutput("endrop_idle_fl", 32'(O_FL), 0);
        checkOutput("endrop_ch_adv", 32'(O_CH), 1);
        repeat (10) @(negedge CLK);
        checkOutput("endrop_no_trig", 32'(O_TRIG), 0);
        I_EN = 1'b1;
        waitTrig(1, 20, c);

        // Asynchronous reset while ch1 is in MEAS.
        waitTrigLow(20, c);
        I_ECHO[1] = 1'b1;
        repeat (40) @(negedge CLK);
        @(posedge CLK);
        #2 RST_n = 1'b0;
        #1;
        checkOutput("arst_trig", 32'(O_TRIG), 0);
        checkOutput("arst_dst", 32'(O_DST), 0);
        checkOutput("arst_oor", 32'(O_OOR), 0);
        checkOutput("arst_vld", 32'(O_VLD), 0);
        checkOutput("arst_ch", 32'(O_CH), 0);
        checkOutput("arst_fl", 32'(O_FL), 0);
        I_ECHO = '0;
        @(negedge CLK);
        RST_n = 1'b1;
        waitTrig(0, 20, c);

        // Write path: 12, then 15 (averaged to 14 when enabled), then OOR, then raw 9.
        runChannel(0, 125);
        checkOutput("wp_first", 32'(O_DST[4:0]), 12);
        for (int k = 1; k < NUM_CH; k++) runChannel(k, 0);
        runChannel(0, 155);
`ifdef HC_SR04_AVG_EN
        checkOutput("wp_second", 32'(O_DST[4:0]), 14);
`else
        checkOutput("wp_second", 32'(O_DST[4:0]), 15);
`endif
        for (int k = 1; k < NUM_CH; k++) runChannel(k, 0);
        runChannel(0, 0);
        checkOutput("wp_oor_dst", 32'(O_DST[4:0]), MAX_RANGE);
        checkOutput("wp_oor_flag", 32'(O_OOR[0]), 1);
        for (int k = 1; k < NUM_CH; k++) runChannel(k, 0);
        runChannel(0, 95);
        checkOutput("wp_after_oor", 32'(O_DST[4:0]), 9);
        checkOutput("wp_after_oor_flag", 32'(O_OOR[0]), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
